rx_lane_descrambler_n: RTL and testbench

//  Parametrised multi-lane receive path for decoded 8b10b symbols. Runs one PCIe Gen1/2

---
 rtl/rx_lane_descrambler_n.sv | 245 ++++++++++++++++++++++++
 tb/tb_rx_lane_descrambler_n.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_lane_descrambler_n.sv
// Multi-lane PCIe Gen1/2 receive path: per-lane descrambling LFSR and ordered-set parser.
// Each lane runs independently; all outputs are registered with one cycle of latency.

module rx_lane_descrambler_n_lane #(
    parameter logic [15:0] LFSR_SEED = 16'hFFFF,
    parameter int          TS_LEN    = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [7:0] byte_i,
    input  logic       ctrl_i,
    input  logic       dis_scr_i,
    output logic [7:0] byte_o,
    output logic [7:0] raw_o,
    output logic       ctrl_o,
    output logic       skp_o,
    output logic       eios_o,
    output logic       fts_o,
    output logic [1:0] ts_o
);
    localparam logic [7:0] K_COM  = 8'hBC;
    localparam logic [7:0] K_SKP  = 8'h1C;
    localparam logic [7:0] K_IDL  = 8'h7C;
    localparam logic [7:0] K_FTS  = 8'h3C;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;
    localparam logic [3:0] TS_LAST = 4'(TS_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_COM, S_SKP, S_IDL, S_FTS, S_TS} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_inc;
    logic [1:0]  id_q, id_d, ts_id;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  byte_q, byte_d, raw_q;
    logic        ctrl_q, skp_q, eios_q, fts_q;
    logic [1:0]  ts_q;
    logic        skp_p, eios_p, fts_p, descr;
    logic [1:0]  ts_p;
    logic        is_com, is_skp, is_idl, is_fts;

    // Galois LFSR x^16+x^5+x^4+x^3+1, eight shifts per symbol
    function automatic logic [15:0] lfsr_adv8(input logic [15:0] l);
        logic [15:0] r;
        r = l;
        for (int i = 0; i < 8; i++)
            r = {r[14:0], 1'b0} ^ (r[15] ? 16'h0039 : 16'h0000);
        return r;
    endfunction

    // First bit shifted out scrambles bit 0 of the symbol
    function automatic logic [7:0] lfsr_byte(input logic [15:0] l);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = l[15-i];
        return b;
    endfunction

    always_comb begin
        is_com  = ctrl_i && (byte_i == K_COM);
        is_skp  = ctrl_i && (byte_i == K_SKP);
        is_idl  = ctrl_i && (byte_i == K_IDL);
        is_fts  = ctrl_i && (byte_i == K_FTS);
        ts_id   = (byte_i == TS1_ID) ? 2'b01 : (byte_i == TS2_ID) ? 2'b10 : 2'b00;
        cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        lfsr_d  = lfsr_q;
        skp_p   = 1'b0;
        eios_p  = 1'b0;
        fts_p   = 1'b0;
        ts_p    = 2'b00;
        if (valid_i) begin
            if (is_com)       lfsr_d = LFSR_SEED;
            else if (!is_skp) lfsr_d = lfsr_adv8(lfsr_q);
            if (is_com) begin
                state_d = S_COM;
                cnt_d   = 4'd0;
            end else begin
                case (state_q)
                    S_IDLE: state_d = S_IDLE;
                    S_COM: begin
                        if (is_skp) begin
                            state_d = S_SKP;
                            skp_p   = 1'b1;
                        end else if (is_idl) begin
                            state_d = S_IDL;
                            cnt_d   = 4'd1;
                        end else if (is_fts) begin
                            state_d = S_FTS;
                            cnt_d   = 4'd1;
                        end else if (!ctrl_i) begin
                            state_d = S_TS;
                            cnt_d   = 4'd1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    S_SKP: if (!is_skp) state_d = S_IDLE;
                    S_IDL: begin
                        if (is_idl) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == 4'd3) begin
                                eios_p  = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    S_FTS: begin
                        if (is_fts) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == 4'd3) begin
                                fts_p   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    S_TS: begin
                        if (ctrl_i) begin
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_inc;
                            // Symbol 6 fixes the TS type; later identifiers must repeat it
                            if (cnt_inc >= 4'd6) begin
                                if (ts_id == 2'b00 || (cnt_inc != 4'd6 && ts_id != id_q)) begin
                                    state_d = S_IDLE;
                                end else begin
                                    id_d = ts_id;
                                    if (cnt_inc == TS_LAST) begin
                                        ts_p    = ts_id;
                                        state_d = S_IDLE;
                                    end
                                end
                            end
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Data following COM opens a training sequence, so it passes through raw with the TS body
    always_comb begin
        descr  = !ctrl_i && !dis_scr_i && (state_q != S_COM) && (state_q != S_TS);
        byte_d = descr ? (byte_i ^ lfsr_byte(lfsr_q)) : byte_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            id_q    <= 2'b00;
            lfsr_q  <= LFSR_SEED;
            byte_q  <= 8'h00;
            raw_q   <= 8'h00;
            ctrl_q  <= 1'b0;
            skp_q   <= 1'b0;
            eios_q  <= 1'b0;
            fts_q   <= 1'b0;
            ts_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            lfsr_q  <= lfsr_d;
            skp_q   <= skp_p;
            eios_q  <= eios_p;
            fts_q   <= fts_p;
            ts_q    <= ts_p;
            if (valid_i) begin
                byte_q <= byte_d;
                raw_q  <= byte_i;
                ctrl_q <= ctrl_i;
            end
        end
    end

    assign byte_o = byte_q;
    assign raw_o  = raw_q;
    assign ctrl_o = ctrl_q;
    assign skp_o  = skp_q;
    assign eios_o = eios_q;
    assign fts_o  = fts_q;
    assign ts_o   = ts_q;
endmodule

module rx_lane_descrambler_n #(
    parameter int          NUM_LANES = 1,
    parameter logic [15:0] LFSR_SEED = 16'hFFFF,
    parameter int          TS_LEN    = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     InValid,
    input  logic [8*NUM_LANES-1:0]   InByte,
    input  logic [NUM_LANES-1:0]     InCtrl,
    input  logic                     DisableScramble,
    output logic                     OutValid,
    output logic [8*NUM_LANES-1:0]   OutByte,
    output logic [8*NUM_LANES-1:0]   OutByteRaw,
    output logic [NUM_LANES-1:0]     OutCtrl,
    output logic [NUM_LANES-1:0]     SkpOrderedSet,
    output logic [NUM_LANES-1:0]     ElecIdleOrderedSet,
    output logic [NUM_LANES-1:0]     FtsOrderedSet,
    output logic [2*NUM_LANES-1:0]   RxTrainingSeq
);
    logic out_valid_q;

    always_ff @(posedge Clk) begin
        if (Reset) out_valid_q <= 1'b0;
        else       out_valid_q <= InValid;
    end

    assign OutValid = out_valid_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        rx_lane_descrambler_n_lane #(
            .LFSR_SEED(LFSR_SEED),
            .TS_LEN   (TS_LEN)
        ) u_lane (
            .clk_i    (Clk),
            .rst_i    (Reset),
            .valid_i  (InValid),
            .byte_i   (InByte[8*g +: 8]),
            .ctrl_i   (InCtrl[g]),
            .dis_scr_i(DisableScramble),
            .byte_o   (OutByte[8*g +: 8]),
            .raw_o    (OutByteRaw[8*g +: 8]),
            .ctrl_o   (OutCtrl[g]),
            .skp_o    (SkpOrderedSet[g]),
            .eios_o   (ElecIdleOrderedSet[g]),
            .fts_o    (FtsOrderedSet[g]),
            .ts_o     (RxTrainingSeq[2*g +: 2])
        );
    end
endmodule

// File: tb/tb_rx_lane_descrambler_n.sv
// Scoreboard bench for rx_lane_descrambler_n with four lanes: stimulus pushes expected
// responses, a negedge monitor pops and compares whenever OutValid is high.

module tb_rx_lane_descrambler_n;
    localparam int NL = 4;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            InValid;
    logic [8*NL-1:0] InByte;
    logic [NL-1:0]   InCtrl;
    logic            DisableScramble;
    logic            OutValid;
    logic [8*NL-1:0] OutByte, OutByteRaw;
    logic [NL-1:0]   OutCtrl, SkpOrderedSet, ElecIdleOrderedSet, FtsOrderedSet;
    logic [2*NL-1:0] RxTrainingSeq;

    rx_lane_descrambler_n #(.NUM_LANES(NL), .LFSR_SEED(16'hFFFF), .TS_LEN(16)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InByte(InByte), .InCtrl(InCtrl),
        .DisableScramble(DisableScramble), .OutValid(OutValid), .OutByte(OutByte),
        .OutByteRaw(OutByteRaw), .OutCtrl(OutCtrl), .SkpOrderedSet(SkpOrderedSet),
        .ElecIdleOrderedSet(ElecIdleOrderedSet), .FtsOrderedSet(FtsOrderedSet),
        .RxTrainingSeq(RxTrainingSeq)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] b;
        logic [31:0] m;
        logic [31:0] raw;
        logic [3:0]  k;
        logic [3:0]  skp, eios, fts;
        logic [7:0]  ts;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   errors = 0;
    int   checks = 0;
    logic chk_zero = 1'b0, chk_hold = 1'b0, chk_drain = 1'b0;
    logic [31:0] hold_val, hold_mask;

    always @(negedge Clk) begin
        if (chk_zero) begin
            checks++;
            if (OutValid !== 1'b0 || OutByte !== '0 || OutByteRaw !== '0 || OutCtrl !== '0 ||
                SkpOrderedSet !== '0 || ElecIdleOrderedSet !== '0 || FtsOrderedSet !== '0 ||
                RxTrainingSeq !== '0) begin
                errors++;
                $display("FAIL reset_zero: vld=%b byte=%h raw=%h ctrl=%b skp=%b ei=%b fts=%b ts=%b, all required 0",
                         OutValid, OutByte, OutByteRaw, OutCtrl, SkpOrderedSet,
                         ElecIdleOrderedSet, FtsOrderedSet, RxTrainingSeq);
            end
        end
        if (chk_hold) begin
            checks++;
            if (OutValid !== 1'b0 || SkpOrderedSet !== '0 || ElecIdleOrderedSet !== '0 ||
                FtsOrderedSet !== '0 || RxTrainingSeq !== '0 ||
                (OutByte & hold_mask) !== (hold_val & hold_mask)) begin
                errors++;
                $display("FAIL invalid_hold: vld=%b ts=%b byte=%h, required vld=0 flags=0 byte=%h (mask %h)",
                         OutValid, RxTrainingSeq, OutByte, hold_val, hold_mask);
            end
        end
        if (chk_drain) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expected outputs never appeared, required 0", q.size());
            end
        end
        if (OutValid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: OutValid=1 byte=%h with empty scoreboard", OutByte);
            end else begin
                me = q.pop_front();
                checks++;
                if ((OutByte & me.m) !== (me.b & me.m) || OutByteRaw !== me.raw || OutCtrl !== me.k) begin
                    errors++;
                    $display("FAIL data: byte=%h raw=%h ctrl=%b, required byte=%h (mask %h) raw=%h ctrl=%b",
                             OutByte, OutByteRaw, OutCtrl, me.b, me.m, me.raw, me.k);
                end
                checks++;
                if (SkpOrderedSet !== me.skp || ElecIdleOrderedSet !== me.eios ||
                    FtsOrderedSet !== me.fts || RxTrainingSeq !== me.ts) begin
                    errors++;
                    $display("FAIL flags: skp=%b ei=%b fts=%b ts=%b, required skp=%b ei=%b fts=%b ts=%b",
                             SkpOrderedSet, ElecIdleOrderedSet, FtsOrderedSet, RxTrainingSeq,
                             me.skp, me.eios, me.fts, me.ts);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic r, input logic [31:0] b,
                         input logic [3:0] k, input logic dis);
        @(posedge Clk);
        #1;
        Reset = r; InValid = v; InByte = b; InCtrl = k; DisableScramble = dis;
    endtask

    task automatic issue(input logic [31:0] b, input logic [3:0] k, input logic dis,
                         input logic [31:0] eb, input logic [31:0] m,
                         input logic [3:0] skp, input logic [3:0] eios,
                         input logic [3:0] fts, input logic [7:0] ts);
        exp_t e;
        drive(1'b1, 1'b0, b, k, dis);
        e.b = eb; e.m = m; e.raw = b; e.k = k;
        e.skp = skp; e.eios = eios; e.fts = fts; e.ts = ts;
        q.push_back(e);
    endtask

    // Same symbol on every lane
    task automatic send(input logic [7:0] b, input logic k, input logic dis,
                        input logic [7:0] eb, input logic chk_b,
                        input logic skp, input logic eios, input logic fts, input logic [1:0] ts);
        issue({4{b}}, {4{k}}, dis, {4{eb}}, chk_b ? 32'hFFFF_FFFF : 32'h0,
              {4{skp}}, {4{eios}}, {4{fts}}, {4{ts}});
    endtask

    task automatic expect_zero();
        @(negedge Clk);
        #1 chk_zero = 1'b1;
        @(negedge Clk);
        #1 chk_zero = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s;
        logic [31:0] b;
        Reset = 1'b1; InValid = 1'b0; InByte = '0; InCtrl = '0; DisableScramble = 1'b0;
        hold_val = '0; hold_mask = '0;

        // Reset dominates a valid COM
        drive(1'b1, 1'b1, {4{8'hBC}}, 4'hF, 1'b0);
        drive(1'b1, 1'b1, {4{8'hBC}}, 4'hF, 1'b0);
        expect_zero();

        // Data straight from the reset seed: FF, 17, C0; then COM passes raw as a K symbol
        send(8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h00, 1'b0, 1'b0, 8'h17, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h00, 1'b0, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

        // SKP: pulse on first 1C only, LFSR frozen across SKPs
        send(8'hBC, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h1C, 1'b1, 1'b0, 8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        send(8'h1C, 1'b1, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h00, 1'b0, 1'b0, 8'h17, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

        // TS2 then TS1, passed through raw, flag on symbol 15 only
        send(8'hBC, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 1; i <= 15; i++) begin
            s = (i < 6) ? 8'(i) : 8'h45;
            send(s, 1'b0, 1'b0, s, 1'b1, 1'b0, 1'b0, 1'b0, (i == 15) ? 2'b10 : 2'b00);
        end
        send(8'hBC, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 1; i <= 15; i++) begin
            s = (i < 6) ? 8'(8'h10 + i) : 8'h4A;
            send(s, 1'b0, 1'b0, s, 1'b1, 1'b0, 1'b0, 1'b0, (i == 15) ? 2'b01 : 2'b00);
        end

        // TS1 with a TS2 identifier at symbol 10: aborted, tail is ordinary data
        send(8'hBC, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 1; i <= 15; i++) begin
            s = (i < 6) ? 8'(i) : (i == 10) ? 8'h45 : 8'h4A;
            send(s, 1'b0, 1'b0, s, (i <= 10), 1'b0, 1'b0, 1'b0, 2'b00);
        end

        // Electrical idle, an IDL run broken by FTS, then a full FTS set
        send(8'hBC, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h7C, 1'b1, 1'b0, 8'h7C, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h7C, 1'b1, 1'b0, 8'h7C, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h7C, 1'b1, 1'b0, 8'h7C, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        send(8'hBC, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h7C, 1'b1, 1'b0, 8'h7C, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h7C, 1'b1, 1'b0, 8'h7C, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'hBC, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);

        // Lane 2 alone sends TS2 with a 3-cycle InValid gap after symbol 7
        for (int i = 0; i <= 15; i++) begin
            s = (i == 0) ? 8'hBC : (i < 6) ? 8'(i) : 8'h45;
            b = {8'h00, s, 8'h00, 8'h00};
            issue(b, (i == 0) ? 4'b0100 : 4'b0000, 1'b0, b, 32'h00FF_0000,
                  4'b0, 4'b0, 4'b0, (i == 15) ? 8'b0010_0000 : 8'b0);
            if (i == 7) begin
                drive(1'b0, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0);
                drive(1'b0, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0);
                drive(1'b0, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0);
                hold_val  = 32'h0045_0000;
                hold_mask = 32'h00FF_0000;
                chk_hold  = 1'b1;
                @(negedge Clk);
                #1 chk_hold = 1'b0;
            end
        end

        // Reset at TS symbol 8, then seed-based descrambling and bypass
        send(8'hBC, 1'b1, 1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 1; i <= 7; i++) begin
            s = (i < 6) ? 8'(i) : 8'h45;
            send(s, 1'b0, 1'b0, s, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        end
        drive(1'b1, 1'b1, {4{8'h45}}, 4'h0, 1'b0);
        expect_zero();
        send(8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        send(8'h00, 1'b0, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

        drive(1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge Clk);
        @(posedge Clk);
        #1 chk_drain = 1'b1;
        @(negedge Clk);
        #1 chk_drain = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
